// File: rtl/ws2812_bit_enc.sv
// ws2812_bit_enc: WS2812 single-wire line encoder, one data bit per strobe.
// Each accepted bit becomes a high phase of T0H/T1H cycles followed by low
// to the end of a T_BIT-cycle period. A done pulse asks for the next bit.
// Optional build macro WS2812_EARLY_DONE_EN: done pulses DONE_LEAD cycles
// ahead of period end and a one-entry pending buffer keeps the line gapless.
//
// state  | meaning
// S_IDLE | line low, waiting for a strobe
// S_HIGH | high phase of the current bit, cnt runs 0..TH-1
// S_LOW  | low phase, cnt continues to T_BIT-1 then the period ends
module ws2812_bit_enc #(
    parameter logic [15:0] T0H       = 16'd80,
    parameter logic [15:0] T1H       = 16'd160,
    parameter logic [15:0] T_BIT     = 16'd250,
    parameter logic [15:0] DONE_LEAD = 16'd4
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic bit_rdy_in,
    input  logic bit_data_in,
    output logic ws2812_out,
    output logic bit_done_out,
    output logic busy_out,
    output logic ovf_err_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam logic [15:0] LAST_CNT = T_BIT - 16'd1;
    // An illegal timing set leaves the encoder inert instead of emitting a
    // malformed waveform; for legal sets this folds to a constant 1.
    localparam logic PARAMS_OK = (T0H != 16'd0) && (T0H < T1H) && (T1H < LAST_CNT) &&
                                 (DONE_LEAD != 16'd0) && (DONE_LEAD < (T_BIT - T1H));
`ifdef WS2812_EARLY_DONE_EN
    // The pending window opens in the same cycle the early done is visible,
    // so the done register is loaded one count earlier.
    localparam logic [15:0] PEND_CNT = LAST_CNT - DONE_LEAD;
    localparam logic [15:0] DONE_CNT = PEND_CNT - 16'd1;
`endif

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cur_bit_q, cur_bit_d;
    logic        ws_q, ws_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;
    logic [15:0] th_len;
`ifdef WS2812_EARLY_DONE_EN
    logic        pend_vld_q, pend_vld_d;
    logic        pend_bit_q, pend_bit_d;
`endif

    assign th_len = cur_bit_q ? T1H : T0H;

    // Next-state, counter, strobe acceptance and overflow detection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_bit_d = cur_bit_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
`ifdef WS2812_EARLY_DONE_EN
        pend_vld_d = pend_vld_q;
        pend_bit_d = pend_bit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bit_rdy_in && PARAMS_OK) begin
                    state_d   = S_HIGH;
                    cnt_d     = 16'd0;
                    cur_bit_d = bit_data_in;
                end
            end
            S_HIGH: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == th_len - 16'd1) begin
                    state_d = S_LOW;
                end
                if (bit_rdy_in) begin
                    ovf_d = 1'b1;
                end
            end
            S_LOW: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = 16'd0;
`ifdef WS2812_EARLY_DONE_EN
                    if (pend_vld_q) begin
                        state_d    = S_HIGH;
                        cur_bit_d  = pend_bit_q;
                        pend_vld_d = 1'b0;
                        if (bit_rdy_in) begin
                            ovf_d = 1'b1;
                        end
                    end else if (bit_rdy_in) begin
                        state_d   = S_HIGH;
                        cur_bit_d = bit_data_in;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    done_d = 1'b1;
                    if (bit_rdy_in) begin
                        state_d   = S_HIGH;
                        cur_bit_d = bit_data_in;
                    end else begin
                        state_d = S_IDLE;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (bit_rdy_in) begin
`ifdef WS2812_EARLY_DONE_EN
                        if ((cnt_q >= PEND_CNT) && !pend_vld_q) begin
                            pend_vld_d = 1'b1;
                            pend_bit_d = bit_data_in;
                        end else begin
                            ovf_d = 1'b1;
                        end
`else
                        ovf_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef WS2812_EARLY_DONE_EN
        if ((state_q != S_IDLE) && (cnt_q == DONE_CNT)) begin
            done_d = 1'b1;
        end
`endif
        ws_d   = (state_d == S_HIGH);
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset drops the line at once.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            cur_bit_q <= 1'b0;
            ws_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_bit_q <= cur_bit_d;
            ws_q      <= ws_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef WS2812_EARLY_DONE_EN
    // Pending bit buffer for strobes that arrive inside the early-done window.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pend_vld_q <= 1'b0;
            pend_bit_q <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_bit_q <= pend_bit_d;
        end
    end
`endif

    assign ws2812_out   = ws_q;
    assign bit_done_out = done_q;
    assign busy_out     = busy_q;
    assign ovf_err_out  = ovf_q;

endmodule

// File: tb/tb_ws2812_bit_enc.sv
// Self-checking bench for ws2812_bit_enc (default timing parameters).
module tb_ws2812_bit_enc;

    localparam int T0H       = 80;
    localparam int T1H       = 160;
    localparam int T_BIT     = 250;
    localparam int DONE_LEAD = 4;
    localparam int MAXL      = 2500;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b0;
    logic dat = 1'b0;
    logic ws, done, busy, ovf;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    ws2812_bit_enc dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .bit_rdy_in  (rdy),
        .bit_data_in (dat),
        .ws2812_out  (ws),
        .bit_done_out(done),
        .busy_out    (busy),
        .ovf_err_out (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rdy   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Strobe held for exactly one cycle, launched from the next rising edge.
    task automatic strobe(input logic b);
        @(posedge clk);
        #1 rdy = 1'b1;
        dat = b;
        @(posedge clk);
        #1 rdy = 1'b0;
    endtask

    // Observes one bit period until done; optionally injects a stray strobe at
    // the k-th observed cycle after the strobe.
    task automatic measure(input int inj_k, output int first_hi, output int hi, output int lo,
                           output int done_c, output int busy_n, output int timeout);
        first_hi = -1; hi = 0; lo = 0; done_c = -1; busy_n = 0; timeout = 1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (done) begin
                done_c  = cyc;
                timeout = 0;
                break;
            end
            if (ws) begin
                hi++;
                if (first_hi < 0) first_hi = cyc;
            end else if (hi > 0) begin
                lo++;
            end
            if (busy) busy_n++;
            rdy = (k == inj_k);
        end
        rdy = 1'b0;
    endtask

    // Random-run storage and the reference model.
    logic       rv [MAXL];
    logic       dv [MAXL];
    logic [3:0] ev [MAXL];   // {line, done, busy, ovf}

    // Expected waveform from the line-code rules: an accepted strobe at cycle
    // c owns cycles c+1..c+T_BIT; done follows at c+T_BIT+1; a strobe inside
    // an owned period (not at its last cycle) is an overflow.
    task automatic build_model(input int len);
        int bend;
        int ovf_from;
        int th;
        bend = -1;
        ovf_from = len + 1;
        for (int c = 0; c < len; c++) ev[c] = 4'b0000;
        for (int c = 0; c < len; c++) begin
            if (rv[c]) begin
                if (c >= bend) begin
                    th = dv[c] ? T1H : T0H;
                    for (int k = 1; k <= T_BIT; k++) begin
                        if (c + k < len) begin
                            ev[c+k][3] = (k <= th);
                            ev[c+k][1] = 1'b1;
                        end
                    end
                    if (c + T_BIT + 1 < len) ev[c+T_BIT+1][2] = 1'b1;
                    bend = c + T_BIT;
                end else if (c + 1 < ovf_from) begin
                    ovf_from = c + 1;
                end
            end
        end
        for (int c = 0; c < len; c++) if (c >= ovf_from) ev[c][0] = 1'b1;
    endtask

    task automatic run_random(input string name, input int len);
        build_model(len);
        do_reset();
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1 rdy = rv[c];
            dat = dv[c];
            @(negedge clk);
            check($sformatf("%s[%0d]", name, c), {28'd0, ws, done, busy, ovf}, {28'd0, ev[c]});
        end
        rdy = 1'b0;
    endtask

    typedef struct {
        logic data;
        int   exp_hi;
        int   exp_lo;
        int   exp_done_off;
        int   exp_busy;
    } vec_t;

    vec_t tbl[2];

    initial begin
        int fh, hi, lo, dc, bn, to;
        int prev, bad_gap, n_to, gend;
        logic [23:0] pat, dec;
        logic [7:0]  pat8, dec8;

        tbl[0] = '{1'b0, T0H, T_BIT - T0H, T_BIT, T_BIT};
        tbl[1] = '{1'b1, T1H, T_BIT - T1H, T_BIT, T_BIT};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {28'd0, ws, done, busy, ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef WS2812_EARLY_DONE_EN
        for (int i = 0; i < 2; i++) begin
            strobe(tbl[i].data);
            measure(-1, fh, hi, lo, dc, bn, to);
            check($sformatf("single%0d_timeout", i), to, 0);
            check($sformatf("single%0d_high", i), hi, tbl[i].exp_hi);
            check($sformatf("single%0d_low", i), lo, tbl[i].exp_lo);
            check($sformatf("single%0d_done_off", i), dc - fh, tbl[i].exp_done_off);
            check($sformatf("single%0d_busy", i), bn, tbl[i].exp_busy);
        end

        // Closed loop: strobe launched on the cycle after each done pulse.
        pat = 24'hA5C30F;
        dec = 24'd0;
        prev = -1; bad_gap = 0; n_to = 0;
        for (int i = 23; i >= 0; i--) begin
            strobe(pat[i]);
            measure(-1, fh, hi, lo, dc, bn, to);
            n_to += to;
            dec[i] = (hi > (T0H + T1H) / 2);
            if (prev >= 0 && (fh - prev) != 2) bad_gap++;
            prev = dc;
        end
        check("loop_timeouts", n_to, 0);
        check("loop_pattern", {8'd0, dec}, {8'd0, pat});
        check("loop_bad_gaps", bad_gap, 0);
        check("loop_ovf", {31'd0, ovf}, 32'd0);

        // Overflow: stray strobe at cnt=50 of a 1 bit.
        strobe(1'b1);
        measure(51, fh, hi, lo, dc, bn, to);
        check("ovf_timeout", to, 0);
        check("ovf_high", hi, T1H);
        check("ovf_low", lo, T_BIT - T1H);
        check("ovf_done_off", dc - fh, T_BIT);
        check("ovf_flag", {31'd0, ovf}, 32'd1);
        n_to = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) n_to++;
        end
        check("ovf_no_second_done", n_to, 0);
        check("ovf_sticky", {31'd0, ovf}, 32'd1);

        // Reset in the middle of the high phase.
        strobe(1'b0);
        repeat (31) @(negedge clk);
        check("midrst_line_before", {31'd0, ws}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_line_busy", {30'd0, ws, busy}, 32'd0);
        check("midrst_ovf_cleared", {31'd0, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        strobe(1'b0);
        measure(-1, fh, hi, lo, dc, bn, to);
        check("midrst_timeout", to, 0);
        check("midrst_high", hi, T0H);
        check("midrst_low", lo, T_BIT - T0H);
        check("midrst_done_off", dc - fh, T_BIT);

        // Random run A: strobes only when the encoder can accept them.
        gend = -1;
        for (int c = 0; c < MAXL; c++) begin
            dv[c] = 1'($urandom);
            rv[c] = 1'b0;
            if ((c == gend && $urandom_range(1) == 0) || (c > gend && $urandom_range(3) == 0)) begin
                rv[c] = 1'b1;
                gend = c + T_BIT;
            end
        end
        run_random("randA", MAXL);

        // Random run B: unconstrained strobes, overflow expected.
        for (int c = 0; c < 2000; c++) begin
            dv[c] = 1'($urandom);
            rv[c] = ($urandom_range(149) == 0);
        end
        run_random("randB", 2000);
`else
        // Early done: strobe launched on the cycle after each done pulse.
        pat8 = 8'hB4;
        dec8 = 8'd0;
        prev = -1;
        n_to = 0;
        strobe(pat8[7]);
        for (int i = 7; i >= 0; i--) begin
            measure(-1, fh, hi, lo, dc, bn, to);
            n_to += to;
            dec8[i] = (hi > (T0H + T1H) / 2);
            check($sformatf("early_done_off%0d", i), dc - fh, T_BIT - 1 - DONE_LEAD);
            if (prev >= 0) check($sformatf("early_period%0d", i), fh - prev, T_BIT);
            prev = fh;
            if (i > 0) strobe(pat8[i-1]);
        end
        check("early_timeouts", n_to, 0);
        check("early_pattern", {24'd0, dec8}, {24'd0, pat8});
        check("early_ovf", {31'd0, ovf}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_bit_enc.md
Name: ws2812_bit_enc

Overview:
- Line-code stage directly downstream of the WS2812 frame controller.
- Consumes one data bit per bit_rdy_in pulse and drives the single-wire NeoPixel line with the WS2812 0/1 high/low waveform.
- Returns a one-cycle bit_done_in-compatible pulse so the controller can issue the next bit.
- Reset/latch code (line low ≥50 µs) stays the controller's responsibility; this block holds the line low whenever idle.

Parameters:
- T0H, 16'd80, high-phase length in clk_in cycles for a 0 bit (0.4 µs at 200 MHz).
- T1H, 16'd160, high-phase length in clk_in cycles for a 1 bit (0.8 µs).
- T_BIT, 16'd250, total bit period in clk_in cycles (1.25 µs). Legal range: 0 < T0H < T1H < T_BIT-1.
- DONE_LEAD, 16'd4, cycles by which bit_done_out precedes period end; used only with WS2812_EARLY_DONE_EN. Legal range: 1 ≤ DONE_LEAD < T_BIT-T1H.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- bit_rdy_in  input  1  one-cycle strobe: bit_data_in valid
- bit_data_in  input  1  bit to encode, sampled when bit_rdy_in=1
- ws2812_out  output  1  serial line to LED chain
- bit_done_out  output  1  one-cycle pulse: encoder can take next bit
- busy_out  output  1  high while a bit period is in progress
- ovf_err_out  output  1  sticky: strobe arrived when it could not be accepted

Behaviour:
- Reset: asynchronous on rst_n_in low; all outputs 0; state IDLE; cnt=0; pending buffer empty. Mid-bit reset aborts the waveform; line drops low immediately.
- All outputs are registered.
- States:
  - IDLE: ws2812_out=0, busy_out=0. bit_rdy_in=1 latches bit_data_in into cur_bit and moves to HIGH. First high cycle appears on the line the cycle after the strobe (1-cycle latency).
  - HIGH: ws2812_out=1; cnt counts 0..TH-1, where TH=T1H if cur_bit else T0H. At cnt=TH-1 go to LOW; cnt keeps counting and is not reset.
  - LOW: ws2812_out=0; cnt continues to T_BIT-1. At cnt=T_BIT-1 pulse bit_done_out (base build), cnt←0, go to IDLE.
- Counter: 16-bit unsigned; never wraps because it is cleared at T_BIT-1.
- busy_out=1 in HIGH and LOW.
- Simultaneous events (base build): bit_rdy_in in the same cycle as the LOW→IDLE transition (cnt=T_BIT-1) is accepted. Next state is HIGH with cnt=0, giving a back-to-back bit with no idle gap.
- Overflow: bit_rdy_in in HIGH, or in LOW with cnt<T_BIT-1, is ignored and sets ovf_err_out=1. ovf_err_out clears only on reset.
- bit_done_out is never asserted twice for one bit and never asserted without a preceding accepted strobe.

Optional Feature:
- Macro: WS2812_EARLY_DONE_EN.
- Defined:
  - bit_done_out pulses at cnt=T_BIT-1-DONE_LEAD instead of T_BIT-1, hiding controller round-trip latency.
  - A one-entry pending buffer (pend_vld, pend_bit) accepts a strobe arriving from that cycle up to and including cnt=T_BIT-1.
  - At cnt=T_BIT-1 with pend_vld=1: go directly to HIGH with cur_bit=pend_bit and clear pend_vld. The line sees no gap.
  - A strobe while pend_vld=1 already sets ovf_err_out and does not overwrite the buffer.
  - In IDLE, a strobe bypasses the buffer.
- Undefined: base behaviour above; no buffer logic is synthesized.

Test Plan:
- Single 0 bit: reset, bit_rdy_in pulse with data=0 → ws2812_out high exactly 80 cycles, low 170 cycles, one bit_done_out pulse 250 cycles after the first high cycle, busy_out high 250 cycles.
- Single 1 bit: data=1 → high exactly 160 cycles, low 90 cycles, bit_done_out at the same offset as the 0-bit case.
- Closed loop: 24 bits 0xA5C30F, with each strobe issued 2 cycles after bit_done_out → decoded line pattern equals 0xA5C30F MSB-first; each inter-bit low is extended by exactly 2 cycles; ovf_err_out=0.
- Overflow: strobe at cnt=50 of a 1 bit → waveform unchanged, ovf_err_out=1 and it stays set; a second bit_done_out does not appear.
- Reset mid-HIGH: assert rst_n_in low at cnt=30 → ws2812_out=0 and busy_out=0 immediately; after release, a new strobe produces a full correct bit.
- WS2812_EARLY_DONE_EN: 8 bits, with each strobe issued 2 cycles after bit_done_out → bit_done_out at offset 245; line shows 8 contiguous 250-cycle periods with no gaps; ovf_err_out=0.
